// File: rtl/or1200_fetch_top.sv
// Reduced OR1200 front end: sequential instruction fetch over Wishbone with
// bus-clock-ratio pacing, interrupt entry, bus-error vectoring and l.rfe return.
module or1200_fetch_top #(
    parameter int                  PIC_INTS     = 20,
    parameter logic [PIC_INTS-1:0] PIC_MASK_RST = '1,
    parameter logic [31:0]         RESET_VEC    = 32'h0000_0100
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [PIC_INTS-1:0] pic_ints_i,
    input  logic [1:0]          clmode_i,
    input  logic [31:0]         iwb_dat_i,
    input  logic                iwb_ack_i,
    input  logic                iwb_err_i,
    output logic                iwb_cyc_o,
    output logic                iwb_stb_o,
    output logic                iwb_we_o,
    output logic [3:0]          iwb_sel_o,
    output logic [31:0]         iwb_adr_o,
    output logic [31:0]         iwb_dat_o,
    output logic [31:0]         insn_o,
    output logic                insn_valid_o,
    output logic [31:0]         pc_o,
    output logic [31:0]         epcr_o,
    output logic                ie_o
);

    localparam logic [31:0]         INSN_RFE    = 32'h2400_0000;
    localparam logic [31:0]         VEC_INT     = 32'h0000_0800;
    localparam logic [31:0]         VEC_BUS_ERR = 32'h0000_0200;
    localparam logic [PIC_INTS-1:0] INT_MASK    = PIC_MASK_RST | PIC_INTS'(3);

    typedef enum logic {IDLE, REQ} state_t;

    state_t      state_q, state_d;
    logic [1:0]  div_q;
    logic        tick;
    logic [31:0] adr_q, adr_d, adr_seq;
    logic [31:0] insn_q, insn_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epcr_q, epcr_d;
    logic        ie_q, ie_d;
    logic        valid_q, valid_d;

    // Bus-enable tick; the divider phase 0 is always a tick, so the first
    // cycle after reset release is a tick in every clock mode.
    always_comb begin
        unique case (clmode_i)
            2'b01:   tick = ~div_q[0];
            2'b11:   tick = (div_q == 2'd0);
            default: tick = 1'b1;
        endcase
    end

    assign adr_seq = adr_q + 32'd4;

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        insn_d  = insn_q;
        pc_d    = pc_q;
        epcr_d  = epcr_q;
        ie_d    = ie_q;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tick) state_d = REQ;
            end
            REQ: begin
                if (tick && iwb_err_i) begin
                    state_d = IDLE;
                    epcr_d  = adr_q;
                    ie_d    = 1'b0;
                    adr_d   = VEC_BUS_ERR;
                end else if (tick && iwb_ack_i) begin
                    state_d = IDLE;
                    insn_d  = iwb_dat_i;
                    pc_d    = adr_q;
                    valid_d = 1'b1;
                    if (iwb_dat_i == INSN_RFE) begin
                        adr_d = epcr_q;
                        ie_d  = 1'b1;
                    end else if (ie_q && |(pic_ints_i & INT_MASK)) begin
                        epcr_d = adr_seq;
                        ie_d   = 1'b0;
                        adr_d  = VEC_INT;
                    end else begin
                        adr_d = adr_seq;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            div_q   <= 2'd0;
            adr_q   <= {RESET_VEC[31:2], 2'b00};
            insn_q  <= 32'd0;
            pc_q    <= 32'd0;
            epcr_q  <= 32'd0;
            ie_q    <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_q + 2'd1;
            adr_q   <= adr_d;
            insn_q  <= insn_d;
            pc_q    <= pc_d;
            epcr_q  <= epcr_d;
            ie_q    <= ie_d;
            valid_q <= valid_d;
        end
    end

    assign iwb_cyc_o    = (state_q == REQ);
    assign iwb_stb_o    = (state_q == REQ);
    assign iwb_we_o     = 1'b0;
    assign iwb_sel_o    = 4'hF;
    assign iwb_adr_o    = adr_q;
    assign iwb_dat_o    = 32'd0;
    assign insn_o       = insn_q;
    assign insn_valid_o = valid_q;
    assign pc_o         = pc_q;
    assign epcr_o       = epcr_q;
    assign ie_o         = ie_q;

endmodule

// File: tb/tb_or1200_fetch_top.sv
// Bench for or1200_fetch_top: directed vector table, clock-mode and reset
// sequences, randomized transactions against a transaction-level model.
module tb_or1200_fetch_top;

    localparam logic [31:0] NOP = 32'h1500_0000;
    localparam logic [31:0] RFE = 32'h2400_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] ints;
    logic [1:0]  clmode;
    logic [31:0] dat;
    logic        ack, err, ack2, err2;

    logic        cyc, stb, we, valid, ie;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o, insn, pc, epcr;

    logic        w_cyc, w_stb, w_we, w_valid, w_ie;
    logic [3:0]  w_sel;
    logic [31:0] w_adr, w_dat_o, w_insn, w_pc, w_epcr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    or1200_fetch_top dut (
        .clk_i(clk), .rst_i(rst), .pic_ints_i(ints), .clmode_i(clmode),
        .iwb_dat_i(dat), .iwb_ack_i(ack), .iwb_err_i(err),
        .iwb_cyc_o(cyc), .iwb_stb_o(stb), .iwb_we_o(we), .iwb_sel_o(sel),
        .iwb_adr_o(adr), .iwb_dat_o(dat_o), .insn_o(insn),
        .insn_valid_o(valid), .pc_o(pc), .epcr_o(epcr), .ie_o(ie)
    );

    // Second instance near the top of the address space with only the
    // always-enabled interrupt lines unmasked.
    or1200_fetch_top #(.PIC_INTS(20), .PIC_MASK_RST(20'h0), .RESET_VEC(32'hFFFF_FFF8)) u_wrap (
        .clk_i(clk), .rst_i(rst), .pic_ints_i(ints), .clmode_i(clmode),
        .iwb_dat_i(dat), .iwb_ack_i(ack2), .iwb_err_i(err2),
        .iwb_cyc_o(w_cyc), .iwb_stb_o(w_stb), .iwb_we_o(w_we), .iwb_sel_o(w_sel),
        .iwb_adr_o(w_adr), .iwb_dat_o(w_dat_o), .insn_o(w_insn),
        .insn_valid_o(w_valid), .pc_o(w_pc), .epcr_o(w_epcr), .ie_o(w_ie)
    );

    typedef struct {
        logic [31:0] fetch_adr;
        logic        ack;
        logic        err;
        logic [31:0] data;
        logic [19:0] irq;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_next;
        logic [31:0] exp_epcr;
        logic        exp_ie;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n, input logic [1:0] mode);
        rst = 1'b1; ack = 1'b0; err = 1'b0; ack2 = 1'b0; err2 = 1'b0;
        ints = '0; dat = '0; clmode = mode;
        repeat (n) step();
        rst = 1'b0;
    endtask

    // One bus transaction: wait for the request, hold the response until the
    // DUT accepts it (cyc drops), then withdraw it.
    task automatic run_xfer(input logic a, input logic e, input logic [31:0] d,
                            input logic [19:0] irq, output logic [31:0] req_adr);
        for (int k = 0; k < 8 && !cyc; k++) step();
        check("req_wait", 32'(cyc), 32'd1);
        req_adr = adr;
        ack = a; err = e; dat = d; ints = irq;
        for (int k = 0; k < 8; k++) begin
            step();
            if (!cyc) break;
        end
        check("resp_wait", 32'(cyc), 32'd0);
        ack = 1'b0; err = 1'b0; ints = '0; dat = '0;
    endtask

    initial begin
        logic [31:0] got;
        int          bad, pulses;
        logic [31:0] pc_m, epcr_m, lpc_m, linsn_m;
        logic        ie_m;
        logic        a, e;
        logic [31:0] d;
        logic [19:0] irq;

        vecs[0] = '{32'h100, 1'b1, 1'b0, NOP, 20'h0,     1'b1, 32'h100, 32'h104, 32'h0,   1'b1};
        vecs[1] = '{32'h104, 1'b1, 1'b0, NOP, 20'h00020, 1'b1, 32'h104, 32'h800, 32'h108, 1'b0};
        vecs[2] = '{32'h800, 1'b1, 1'b0, RFE, 20'h0,     1'b1, 32'h800, 32'h108, 32'h108, 1'b1};
        vecs[3] = '{32'h108, 1'b1, 1'b0, NOP, 20'h0,     1'b1, 32'h108, 32'h10C, 32'h108, 1'b1};
        vecs[4] = '{32'h10C, 1'b0, 1'b1, NOP, 20'h0,     1'b0, 32'h108, 32'h200, 32'h10C, 1'b0};
        vecs[5] = '{32'h200, 1'b1, 1'b0, NOP, 20'h00001, 1'b1, 32'h200, 32'h204, 32'h10C, 1'b0};
        vecs[6] = '{32'h204, 1'b1, 1'b0, RFE, 20'h0,     1'b1, 32'h204, 32'h10C, 32'h10C, 1'b1};
        vecs[7] = '{32'h10C, 1'b1, 1'b1, NOP, 20'h0,     1'b0, 32'h204, 32'h200, 32'h10C, 1'b0};
        vecs[8] = '{32'h200, 1'b1, 1'b0, RFE, 20'h0,     1'b1, 32'h200, 32'h10C, 32'h10C, 1'b1};
        vecs[9] = '{32'h10C, 1'b1, 1'b0, NOP, 20'h0,     1'b1, 32'h10C, 32'h110, 32'h10C, 1'b1};

        // Reset values, then a 50-cycle stall with no acknowledge.
        do_reset(10, 2'b00);
        check("rst_cyc", 32'(cyc), 32'd0);
        check("rst_stb", 32'(stb), 32'd0);
        check("rst_adr", adr, 32'h100);
        check("rst_insn", insn, 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_epcr", epcr, 32'd0);
        check("rst_ie", 32'(ie), 32'd1);
        check("const_we", 32'(we), 32'd0);
        check("const_sel", 32'(sel), 32'hF);
        check("const_dat", dat_o, 32'd0);
        bad = 0; pulses = 0;
        step();
        repeat (50) begin
            if (!cyc || !stb || adr != 32'h100) bad++;
            if (valid) pulses++;
            step();
        end
        check("stall_hold", 32'(bad), 32'd0);
        check("stall_valid", 32'(pulses), 32'd0);

        // Directed transactions: sequential, interrupt, l.rfe, bus errors.
        for (int i = 0; i < 10; i++) begin
            run_xfer(vecs[i].ack, vecs[i].err, vecs[i].data, vecs[i].irq, got);
            check($sformatf("vec%0d_fetch_adr", i), got, vecs[i].fetch_adr);
            check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
            check($sformatf("vec%0d_next_adr", i), adr, vecs[i].exp_next);
            check($sformatf("vec%0d_epcr", i), epcr, vecs[i].exp_epcr);
            check($sformatf("vec%0d_ie", i), 32'(ie), 32'(vecs[i].exp_ie));
            if (vecs[i].exp_valid) check($sformatf("vec%0d_insn", i), insn, vecs[i].data);
        end
        step();
        check("valid_one_cycle", 32'(valid), 32'd0);

        // Reset in the middle of the request at 0x110, with an ack arriving.
        check("mid_req_cyc", 32'(cyc), 32'd1);
        check("mid_req_adr", adr, 32'h110);
        rst = 1'b1; ack = 1'b1; dat = NOP;
        step();
        check("mid_rst_cyc", 32'(cyc), 32'd0);
        check("mid_rst_adr", adr, 32'h100);
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_insn", insn, 32'd0);
        check("mid_rst_pc", pc, 32'd0);
        check("mid_rst_epcr", epcr, 32'd0);
        check("mid_rst_ie", 32'(ie), 32'd1);
        step();
        check("late_ack_valid", 32'(valid), 32'd0);
        rst = 1'b0; ack = 1'b0;

        // 1:2 mode: request on the first tick, off-tick ack ignored.
        do_reset(4, 2'b01);
        check("m1_stb_pre", 32'(stb), 32'd0);
        step();
        check("m1_stb_first", 32'(stb), 32'd1);
        ack = 1'b1; dat = NOP;
        step();
        check("m1_offtick_valid", 32'(valid), 32'd0);
        check("m1_offtick_cyc", 32'(cyc), 32'd1);
        step();
        check("m1_tick_valid", 32'(valid), 32'd1);
        check("m1_tick_pc", pc, 32'h100);
        ack = 1'b0;

        // 1:4 mode: ack honoured only every fourth cycle.
        do_reset(4, 2'b11);
        step();
        check("m3_cyc_first", 32'(cyc), 32'd1);
        ack = 1'b1; dat = NOP; pulses = 0;
        repeat (3) begin
            step();
            if (valid) pulses++;
        end
        check("m3_early_valid", 32'(pulses), 32'd0);
        step();
        check("m3_tick_valid", 32'(valid), 32'd1);
        ack = 1'b0; bad = 0;
        repeat (3) begin
            step();
            if (cyc) bad++;
        end
        check("m3_idle_wait", 32'(bad), 32'd0);
        step();
        check("m3_next_req", 32'(cyc), 32'd1);
        check("m3_next_adr", adr, 32'h104);

        // Randomized transactions against a transaction-level model.
        for (int seg = 0; seg < 4; seg++) begin
            do_reset(3, 2'(seg));
            pc_m = 32'h100; epcr_m = '0; ie_m = 1'b1; lpc_m = '0; linsn_m = '0;
            for (int t = 0; t < 30; t++) begin
                e   = ($urandom_range(5) == 0);
                a   = e ? ($urandom_range(1) == 1) : 1'b1;
                d   = ($urandom_range(3) == 0) ? RFE : $urandom;
                irq = ($urandom_range(1) == 1) ? 20'(32'd1 << $urandom_range(19)) : 20'h0;
                repeat ($urandom_range(2)) step();
                run_xfer(a, e, d, irq, got);
                check("rnd_fetch_adr", got, pc_m);
                if (e) begin
                    epcr_m = pc_m; ie_m = 1'b0; pc_m = 32'h200;
                end else begin
                    lpc_m = pc_m; linsn_m = d;
                    if (d == RFE) begin
                        pc_m = epcr_m; ie_m = 1'b1;
                    end else if (ie_m && irq != 0) begin
                        epcr_m = pc_m + 32'd4; ie_m = 1'b0; pc_m = 32'h800;
                    end else begin
                        pc_m = pc_m + 32'd4;
                    end
                end
                check("rnd_valid", 32'(valid), 32'(!e));
                check("rnd_insn", insn, linsn_m);
                check("rnd_pc", pc, lpc_m);
                check("rnd_epcr", epcr, epcr_m);
                check("rnd_ie", 32'(ie), 32'(ie_m));
            end
        end

        // Address wrap and fixed-enable interrupt lines on the second instance.
        do_reset(3, 2'b00);
        for (int k = 0; k < 8 && !w_cyc; k++) step();
        check("wrap_req", 32'(w_cyc), 32'd1);
        check("wrap_start_adr", w_adr, 32'hFFFF_FFF8);
        ack2 = 1'b1; dat = NOP;
        step();
        ack2 = 1'b0;
        check("wrap_valid", 32'(w_valid), 32'd1);
        check("wrap_pc0", w_pc, 32'hFFFF_FFF8);
        check("wrap_adr1", w_adr, 32'hFFFF_FFFC);
        step();
        check("wrap_req2", 32'(w_cyc), 32'd1);
        ints = 20'h00020; ack2 = 1'b1;
        step();
        ack2 = 1'b0; ints = '0;
        check("wrap_pc1", w_pc, 32'hFFFF_FFFC);
        check("wrap_to_zero", w_adr, 32'h0);
        check("wrap_masked_ie", 32'(w_ie), 32'd1);
        step();
        ints = 20'h00002; ack2 = 1'b1;
        step();
        ack2 = 1'b0; ints = '0;
        check("wrap_irq1_adr", w_adr, 32'h800);
        check("wrap_irq1_epcr", w_epcr, 32'h4);
        check("wrap_irq1_ie", 32'(w_ie), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
